// File: rtl/handshake_constant_arbiter.sv
// rtl/handshake_constant_arbiter.sv - round-robin arbiter granting dataless tokens onto one registered constant channel
module handshake_constant_arbiter #(
    parameter int NUM_IN      = 4,
    parameter int DATA_WIDTH  = 32,
    parameter     CONST_VALUE = 0,
    parameter int INDEX_WIDTH = $clog2(NUM_IN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_IN-1:0]      ctrl_valid,
    output logic [NUM_IN-1:0]      ctrl_ready,
    output logic [DATA_WIDTH-1:0]  outs,
    output logic [INDEX_WIDTH-1:0] outs_index,
    output logic                   outs_valid,
    input  logic                   outs_ready
);

    localparam logic [DATA_WIDTH-1:0] L_CONST = DATA_WIDTH'(CONST_VALUE);

    logic                   r_valid;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [INDEX_WIDTH-1:0] r_index;
    logic [INDEX_WIDTH-1:0] r_ptr;

    logic                   w_accept;
    logic                   w_any;
    logic                   w_xfer;
    logic [INDEX_WIDTH-1:0] w_grant;
    logic [INDEX_WIDTH-1:0] w_scan_idx;
    logic [INDEX_WIDTH-1:0] w_ptr_next;

    assign w_accept = !r_valid || outs_ready;

    // Scan from the far end back toward ptr so the last hit is the closest requester.
    always_comb begin
        w_any      = 1'b0;
        w_grant    = '0;
        w_scan_idx = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            w_scan_idx = INDEX_WIDTH'((int'(r_ptr) + k) % NUM_IN);
            if (ctrl_valid[w_scan_idx]) begin
                w_any   = 1'b1;
                w_grant = w_scan_idx;
            end
        end
    end

    assign w_xfer     = w_any && w_accept && rst;
    assign w_ptr_next = (w_grant == INDEX_WIDTH'(NUM_IN - 1)) ? '0 : w_grant + 1'b1;

    always_comb begin
        ctrl_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            ctrl_ready[i] = w_xfer && (w_grant == INDEX_WIDTH'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_index <= '0;
            r_ptr   <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= L_CONST;
            r_index <= w_grant;
            r_ptr   <= w_ptr_next;
        end else if (r_valid && outs_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign outs       = r_data;
    assign outs_index = r_index;
    assign outs_valid = r_valid;

endmodule

// File: tb/tb_handshake_constant_arbiter.sv
// tb/tb_handshake_constant_arbiter.sv - randomized and directed bench against a token-level reference model
module tb_handshake_constant_arbiter;

    localparam int          N      = 4;
    localparam int          DW     = 17;
    localparam logic [16:0] CONSTV = 17'h1E951;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  ctrl_valid;
    logic [N-1:0]  ctrl_ready;
    logic [DW-1:0] outs;
    logic [1:0]    outs_index;
    logic          outs_valid;
    logic          outs_ready;

    int checks = 0;
    int errors = 0;

    // Reference model: the single buffered token and the next requester in line.
    logic        m_valid;
    logic [16:0] m_data;
    int          m_index;
    int          m_ptr;

    handshake_constant_arbiter #(
        .NUM_IN(N),
        .DATA_WIDTH(DW),
        .CONST_VALUE(CONSTV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ctrl_valid(ctrl_valid),
        .ctrl_ready(ctrl_ready),
        .outs(outs),
        .outs_index(outs_index),
        .outs_valid(outs_valid),
        .outs_ready(outs_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive at the falling edge, check settled outputs, advance the model.
    task automatic step(input logic [N-1:0] v, input logic ordy, input logic rn);
        int          g;
        logic [N-1:0] exp_ready;
        ctrl_valid = v;
        outs_ready = ordy;
        rst        = rn;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        exp_ready = '0;
        if (rn && g >= 0 && (!m_valid || ordy)) exp_ready[g] = 1'b1;
        check("ctrl_ready", 32'(ctrl_ready), 32'(exp_ready));
        check("outs_valid", 32'(outs_valid), 32'(m_valid));
        check("outs", 32'(outs), 32'(m_data));
        check("outs_index", 32'(outs_index), 32'(m_index));
        if (!rn) begin
            m_valid = 1'b0; m_data = '0; m_index = 0; m_ptr = 0;
        end else if (exp_ready != 0) begin
            m_valid = 1'b1; m_data = CONSTV; m_index = g; m_ptr = (g + 1) % N;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; ctrl_valid = '0; outs_ready = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        m_valid = 1'b0; m_data = '0; m_index = 0; m_ptr = 0;

        for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(4'b0100, 1'b1, 1'b1);

        step(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(4'b1111, 1'b1, 1'b1);

        step(4'b0000, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b1100, 1'b0, 1'b1);
        step(4'b1100, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b1);

        step(4'b0100, 1'b1, 1'b1);
        step(4'b1001, 1'b1, 1'b1);
        step(4'b1001, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b1);

        step(4'b0001, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b1);

        for (int i = 0; i < 400; i++) begin
            step(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/handshake_constant_arbiter.md
# handshake_constant_arbiter

Round-robin arbiter that shares one elastic constant source among `NUM_IN` control-token requesters. Each requester presents a dataless `ctrl_valid`/`ctrl_ready` token. The block grants one token per cycle and emits `CONST_VALUE` on a single registered output channel, tagged with the winning requester's index. It sits between several control-flow producers and a downstream consumer that needs the same constant on behalf of whichever producer fired.

## Interface
Parameters:
- `NUM_IN`, 4, number of requesting control channels; legal range 2..16.
- `DATA_WIDTH`, 32, width of `outs`.
- `CONST_VALUE`, 0, constant emitted on every output token; truncated or zero-extended to `DATA_WIDTH`.
- `INDEX_WIDTH`, `$clog2(NUM_IN)`, width of `outs_index`; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `ctrl_valid`  in  `NUM_IN`  per-requester token valid; bit i belongs to requester i.
- `ctrl_ready`  out  `NUM_IN`  per-requester grant/ready; at most one bit high.
- `outs`  out  `DATA_WIDTH`  registered constant.
- `outs_index`  out  `INDEX_WIDTH`  index of the requester whose token produced the current output.
- `outs_valid`  out  1  output token valid.
- `outs_ready`  in  1  downstream ready.

## Operation
State:
- Output register: `valid_q`, `data_q`, `index_q`.
- Round-robin pointer `ptr` (`INDEX_WIDTH` bits, range 0..`NUM_IN`-1).

Reset (`rst`==0 at a rising edge) clears everything:
- `valid_q`=0, `data_q`=0, `index_q`=0, `ptr`=0.
- While `rst`==0, `ctrl_ready` is forced to all-zero combinationally.

Combinational control:
- `accept` = `!valid_q || outs_ready`.
- Grant `g` is the first i with `ctrl_valid[i]`=1, scanning `ptr`, `ptr+1`, … modulo `NUM_IN`.
- `ctrl_ready[g]` = `accept && rst`; every other bit of `ctrl_ready` is 0.
- If no `ctrl_valid` bit is set, `ctrl_ready` is 0.

Grant is not locked:
- It is recomputed every cycle.
- A requester that drops `ctrl_valid` without a handshake simply loses arbitration.

Sequential update at each rising edge with `rst`==1:
- **Input transfer** (`ctrl_valid[g] && ctrl_ready[g]`): `valid_q`<=1, `data_q`<=`CONST_VALUE`, `index_q`<=g, `ptr`<=(g+1) mod `NUM_IN`. Wrap from `NUM_IN`-1 to 0; for non-power-of-2 `NUM_IN` the pointer never takes values ≥ `NUM_IN`.
- **Output drain only** (`valid_q && outs_ready`, no input transfer): `valid_q`<=0; `data_q`, `index_q` and `ptr` hold.
- **Neither**: all state holds.

Outputs:
- `outs`=`data_q`, `outs_index`=`index_q`, `outs_valid`=`valid_q`.
- While `valid_q`=1 and `outs_ready`=0, `outs` and `outs_index` are stable.

## Timing
- Latency: a token accepted at edge N appears with `outs_valid`=1 in the cycle after edge N (one register stage).
- Throughput: one token per cycle under continuous `outs_ready`=1. A drain and a load in the same cycle are required; there are no bubbles.
- Backpressure: with `valid_q`=1 and `outs_ready`=0, `ctrl_ready` is all-zero and `ptr` holds.
- `ctrl_ready` depends combinationally on `ctrl_valid`, `outs_ready`, `rst` and state. It never depends combinationally on `ctrl_ready` itself.
- Reset mid-operation: any buffered token is discarded at the reset edge. `outs_valid`=0 from the next cycle on, and `ptr` returns to 0.
- Fairness: with all requesters continuously valid and no backpressure, each requester is granted exactly once every `NUM_IN` cycles.

## Test plan
All scenarios use `NUM_IN`=4, `DATA_WIDTH`=17, `CONST_VALUE`=17'h1E951.
- **Reset:** `rst`=0 for 3 cycles with `ctrl_valid`=4'b1111, `outs_ready`=1 -> `ctrl_ready`=4'b0000, `outs_valid`=0, `outs`=0, `outs_index`=0 throughout.
- **Single requester:** `ctrl_valid`=4'b0100 held, `outs_ready`=1 -> `ctrl_ready`=4'b0100 every cycle. From the cycle after the first handshake, `outs_valid`=1 continuously, `outs`=17'h1E951, `outs_index`=2.
- **Round robin:** `ctrl_valid`=4'b1111 held, `outs_ready`=1 from reset -> `outs_index` sequence 0,1,2,3,0,1,…, with one grant per cycle.
- **Backpressure:** `outs_valid`=1 with `outs_index`=1, `outs_ready`=0 for 3 cycles, requesters 2 and 3 valid -> `ctrl_ready`=4'b0000, and `outs`/`outs_index` are stable. On the cycle `outs_ready` rises, `ctrl_ready`=4'b0100 and the next output shows `outs_index`=2.
- **Pointer wrap:** after a grant to requester 2 (`ptr`=3), `ctrl_valid`=4'b1001 -> requester 3 is granted first, then requester 0; the output index sequence is 3,0.
- **Reset mid-operation:** `outs_valid`=1, `outs_ready`=0, then `rst`=0 for one edge -> `outs_valid`=0 next cycle and the token is never delivered. After `rst`=1 with `ctrl_valid`=4'b1111, the first grant is to requester 0.
